// File: rtl/up_dn_pkg.sv
// rtl/up_dn_pkg.sv - shared types and width defaults for the up/down sweep controller
// Contents: sweep FSM state enum, default counter and sweep-count widths.
package up_dn_pkg;

   localparam int CNT_W_DEF = 5;
   localparam int SW_W_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_UP   = 2'd2,
      ST_DOWN = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/up_dn_counter.sv
// rtl/up_dn_counter.sv - loadable up/down counter driven by the sweep controller
// Ports: clk, rst_n (async active-low), load/down/up commands (load > down > up),
//        load_val (value taken on load), cnt (current count).
module Up_Dn_Counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         up,
   input  logic         down,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (down) begin
         cnt_d = cnt_q - 1'b1;
      end else if (up) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/up_dn_sweep_ctrl.sv
// rtl/up_dn_sweep_ctrl.sv - drives an up/down counter through repeated lo->hi->lo sweeps
// Ports: clk, rst_n (async active-low); start/stop job control; lo_bnd/hi_bnd/n_sweeps job
//        setup; cnt_val counter feedback; load/load_val/up/down counter commands;
//        busy, done pulse, sweep_cnt, sticky err status. All outputs are registered.
module up_dn_sweep_ctrl
   import up_dn_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int SW_W  = SW_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] lo_bnd,
   input  logic [CNT_W-1:0] hi_bnd,
   input  logic [SW_W-1:0]  n_sweeps,
   input  logic [CNT_W-1:0] cnt_val,
   output logic             load,
   output logic [CNT_W-1:0] load_val,
   output logic             up,
   output logic             down,
   output logic             busy,
   output logic             done,
   output logic [SW_W-1:0]  sweep_cnt,
   output logic             err
);

   sweep_state_e     state_q, state_d;
   logic [CNT_W-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] load_val_q, load_val_d;
   logic             load_q, load_d;
   logic             up_q, up_d;
   logic             down_q, down_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [SW_W-1:0]  sweep_cnt_q, sweep_cnt_d;
   logic             err_q, err_d;

   logic [CNT_W-1:0] shadow_inc;
   logic [CNT_W-1:0] shadow_dec;
   logic [SW_W-1:0]  sweep_nxt;
   logic             mismatch;

   assign shadow_inc = shadow_q + 1'b1;
   assign shadow_dec = shadow_q - 1'b1;
   assign sweep_nxt  = sweep_cnt_q + 1'b1;
   // Shadow tracks what the counter should hold once the previous command has landed.
   assign mismatch   = (cnt_val != shadow_q);

   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      shadow_d    = shadow_q;
      load_val_d  = load_val_q;
      sweep_cnt_d = sweep_cnt_q;
      err_d       = err_q;
      busy_d      = busy_q;
      load_d      = 1'b0;
      up_d        = 1'b0;
      down_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start && !stop) begin
               if (lo_bnd < hi_bnd) begin
                  lo_d        = lo_bnd;
                  hi_d        = hi_bnd;
                  sweep_cnt_d = '0;
                  err_d       = 1'b0;
                  load_d      = 1'b1;
                  load_val_d  = lo_bnd;
                  busy_d      = 1'b1;
                  state_d     = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (stop) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               // Counter takes load_val on this edge, so the shadow can start at lo.
               shadow_d = lo_q;
               up_d     = 1'b1;
               state_d  = ST_UP;
            end
         end

         ST_UP: begin
            if (stop || mismatch) begin
               err_d   = err_q | mismatch;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               shadow_d = shadow_inc;
               if (shadow_inc == hi_q) begin
                  down_d  = 1'b1;
                  state_d = ST_DOWN;
               end else begin
                  up_d = 1'b1;
               end
            end
         end

         ST_DOWN: begin
            if (stop || mismatch) begin
               err_d   = err_q | mismatch;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               shadow_d = shadow_dec;
               if (shadow_dec == lo_q) begin
                  sweep_cnt_d = sweep_nxt;
                  // n_sweeps of zero means sweep until stopped.
                  if ((n_sweeps != '0) && (sweep_nxt == n_sweeps)) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     up_d    = 1'b1;
                     state_d = ST_UP;
                  end
               end else begin
                  down_d = 1'b1;
               end
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lo_q        <= '0;
         hi_q        <= '0;
         shadow_q    <= '0;
         load_val_q  <= '0;
         load_q      <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sweep_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         shadow_q    <= shadow_d;
         load_val_q  <= load_val_d;
         load_q      <= load_d;
         up_q        <= up_d;
         down_q      <= down_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sweep_cnt_q <= sweep_cnt_d;
         err_q       <= err_d;
      end
   end

   assign load      = load_q;
   assign load_val  = load_val_q;
   assign up        = up_q;
   assign down      = down_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sweep_cnt = sweep_cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_up_dn_sweep_ctrl.sv
// tb/tb_up_dn_sweep_ctrl.sv - self-checking bench for up_dn_sweep_ctrl with its up/down counter
module tb_up_dn_sweep_ctrl;
   import up_dn_pkg::*;

   localparam int CW = 5;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop;
   logic [CW-1:0] lo_bnd, hi_bnd;
   logic [SW-1:0] n_sweeps;
   logic [CW-1:0] cnt_val;
   logic          load, up, down, busy, done, err;
   logic [CW-1:0] load_val;
   logic [SW-1:0] sweep_cnt;
   logic [CW-1:0] ctr_q;
   logic          force_en;
   logic [CW-1:0] force_val;

   int n_vec  = 0;
   int n_miss = 0;
   int seq[$];

   always #5 clk = ~clk;

   assign cnt_val = force_en ? force_val : ctr_q;

   up_dn_sweep_ctrl #(.CNT_W(CW), .SW_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .lo_bnd(lo_bnd), .hi_bnd(hi_bnd), .n_sweeps(n_sweeps), .cnt_val(cnt_val),
      .load(load), .load_val(load_val), .up(up), .down(down),
      .busy(busy), .done(done), .sweep_cnt(sweep_cnt), .err(err)
   );

   Up_Dn_Counter #(.W(CW)) u_ctr (
      .clk(clk), .rst_n(rst_n), .load(load), .up(up), .down(down),
      .load_val(load_val), .cnt(ctr_q)
   );

   typedef struct {
      int lo;
      int hi;
      int n;
      int bad;
      int edges;
      int sweeps;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cmds_idle(input string tag);
      chk({tag, "_load"}, load, 0);
      chk({tag, "_up"}, up, 0);
      chk({tag, "_down"}, down, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Expected counter trajectory: lo, climb to hi, fall back to lo, repeated n times.
   function automatic void build_seq(input int lo, input int hi, input int n);
      seq.delete();
      seq.push_back(lo);
      for (int s = 0; s < n; s++) begin
         for (int i = 1; i <= hi - lo; i++) seq.push_back(lo + i);
         for (int i = 1; i <= hi - lo; i++) seq.push_back(hi - i);
      end
   endfunction

   task automatic run_job(input int lo, input int hi, input int n, input int edges,
                          input int sweeps);
      int span;
      span = hi - lo;
      build_seq(lo, hi, n);
      lo_bnd = CW'(lo); hi_bnd = CW'(hi); n_sweeps = SW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_load", load, 1);
      chk("start_load_val", load_val, lo);
      chk("start_busy", busy, 1);
      chk("start_err", err, 0);
      chk("start_sweep_cnt", sweep_cnt, 0);
      for (int k = 1; k <= edges; k++) begin
         tick();
         if (k - 1 < seq.size()) chk("cnt", ctr_q, seq[k-1]);
         chk("busy", busy, (k < edges) ? 1 : 0);
         chk("done", done, (k == edges) ? 1 : 0);
         chk("sweep_cnt", sweep_cnt, ((k - 1) / (2 * span)) % 16);
         chk("onehot", ($countones({load, up, down}) > 1) ? 1 : 0, 0);
      end
      tick();
      chk("done_pulse_end", done, 0);
      chk("cnt_hold", ctr_q, lo);
      chk("final_sweeps", sweep_cnt, sweeps);
      chk_cmds_idle("after_job");
   endtask

   task automatic bad_job(input int lo, input int hi);
      lo_bnd = CW'(lo); hi_bnd = CW'(hi); n_sweeps = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("bad_err", err, 1);
      chk_cmds_idle("bad");
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("bad_err_sticky", err, 1);
         chk_cmds_idle("bad_hold");
      end
   endtask

   // Stop lands in the cycle after edge k; the counter makes one more step then holds.
   task automatic stop_job(input int lo, input int hi, input int k);
      int span;
      span = hi - lo;
      build_seq(lo, hi, 3);
      lo_bnd = CW'(lo); hi_bnd = CW'(hi); n_sweeps = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j <= k; j++) begin
         tick();
         chk("stop_run_cnt", ctr_q, seq[j-1]);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_done", done, 0);
      chk("stop_cnt", ctr_q, seq[k]);
      chk("stop_sweep_hold", sweep_cnt, ((k - 1) / (2 * span)) % 16);
      chk_cmds_idle("stop");
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("stop_cnt_hold", ctr_q, seq[k]);
         chk("stop_no_done", done, 0);
      end
   endtask

   initial begin
      int lo, hi, n, r, k;

      tbl[0] = '{2, 5, 1, 0, 7, 1};
      tbl[1] = '{0, 31, 2, 0, 125, 2};
      tbl[2] = '{7, 7, 1, 1, 0, 0};
      tbl[3] = '{9, 3, 1, 1, 0, 0};
      tbl[4] = '{4, 6, 1, 0, 5, 1};
      tbl[5] = '{3, 4, 3, 0, 7, 3};
      tbl[6] = '{0, 1, 1, 0, 3, 1};
      tbl[7] = '{10, 20, 1, 0, 21, 1};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      lo_bnd = '0; hi_bnd = '0; n_sweeps = '0;
      force_en = 1'b0; force_val = '0;
      repeat (2) tick();
      chk_cmds_idle("reset");
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_sweep_cnt", sweep_cnt, 0);
      chk("reset_load_val", load_val, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].bad != 0) bad_job(tbl[i].lo, tbl[i].hi);
         else run_job(tbl[i].lo, tbl[i].hi, tbl[i].n, tbl[i].edges, tbl[i].sweeps);
      end

      // Stop wins over start in IDLE.
      lo_bnd = 5'd1; hi_bnd = 5'd4; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk_cmds_idle("stop_over_start");

      stop_job(1, 3, 2);

      // Counter feedback corrupted while sweeping up.
      lo_bnd = 5'd1; hi_bnd = 5'd8; n_sweeps = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("pre_force_up", up, 1);
      force_val = ctr_q + 5'd5;
      force_en = 1'b1;
      tick();
      chk("mis_err", err, 1);
      chk("mis_done", done, 0);
      chk_cmds_idle("mis");
      force_en = 1'b0;
      tick();
      chk("mis_no_done", done, 0);
      chk("mis_err_sticky", err, 1);

      // Reset mid-DOWN, then a fresh job.
      lo_bnd = 5'd2; hi_bnd = 5'd6; n_sweeps = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      chk("pre_rst_down", down, 1);
      rst_n = 1'b0;
      #1;
      chk_cmds_idle("async_rst");
      chk("async_rst_done", done, 0);
      chk("async_rst_err", err, 0);
      chk("async_rst_sweep", sweep_cnt, 0);
      chk("async_rst_load_val", load_val, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_job(4, 6, 1, 5, 1);

      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 4);
         if (r == 0) begin
            lo = $urandom_range(0, 31);
            hi = $urandom_range(0, lo);
            bad_job(lo, hi);
         end else if (r == 1) begin
            lo = $urandom_range(0, 25);
            hi = lo + $urandom_range(1, 6);
            k = $urandom_range(1, 6 * (hi - lo));
            stop_job(lo, hi, k);
         end else begin
            lo = $urandom_range(0, 25);
            hi = lo + $urandom_range(1, 6);
            n = $urandom_range(1, 3);
            run_job(lo, hi, n, 1 + 2 * (hi - lo) * n, n);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
